// File: rtl/led_mode_controller_if.sv
// Signal bundle between the button debouncer / switch bank and the LED mode controller.
// The master drives the button and switches; the slave drives the LEDs, mode and tick.
interface led_mode_controller_if #(
    parameter int N_LEDS = 8
);
    logic              button_center_db;
    logic [N_LEDS-1:0] switches;
    logic [N_LEDS-1:0] leds;
    logic [1:0]        mode;
    logic              tick;

    modport master (
        output button_center_db,
        output switches,
        input  leds,
        input  mode,
        input  tick
    );

    modport slave (
        input  button_center_db,
        input  switches,
        output leds,
        output mode,
        output tick
    );
endinterface

// File: rtl/led_mode_controller.sv
// Button-driven four-mode LED sequencer (OFF, MIRROR, ROTATE, BLINK).
// The MIRROR and BLINK modes take the LED pattern from the switches; ROTATE and BLINK step on a divided tick.
module led_mode_controller #(
    parameter int N_LEDS   = 8,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    led_mode_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_MIRROR = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    mode_t             state;
    mode_t             next_state;
    logic [N_LEDS-1:0] leds_q;
    logic [CNT_W-1:0]  cnt;
    logic              tick_q;
    logic              phase;
    logic              btn_prev;
    logic              press;
    logic              tick_hit;
    logic              next_phase;

    always_comb begin
        press      = bus.button_center_db & ~btn_prev;
        tick_hit   = (cnt == CNT_LAST);
        next_state = mode_t'(state + 2'd1);
        next_phase = phase ^ tick_hit;
    end

    // NOTE: all state lives in one clocked block with non-blocking assignments, so every
    // register samples the pre-edge values of the others and the order of statements is irrelevant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MODE_OFF;
            leds_q   <= '0;
            cnt      <= '0;
            tick_q   <= 1'b0;
            phase    <= 1'b0;
            // Starting high hides a button already held when reset releases.
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= bus.button_center_db;
            if (press) begin
                // A press overrides a coincident tick: restart the divider and apply the new mode's entry rule.
                state  <= next_state;
                cnt    <= '0;
                tick_q <= 1'b0;
                case (next_state)
                    MODE_OFF:    leds_q <= '0;
                    MODE_MIRROR: leds_q <= bus.switches;
                    MODE_ROTATE: leds_q <= N_LEDS'(1);
                    MODE_BLINK: begin
                        phase  <= 1'b1;
                        leds_q <= bus.switches;
                    end
                    default:     leds_q <= '0;
                endcase
            end else begin
                tick_q <= tick_hit;
                cnt    <= tick_hit ? '0 : cnt + 1'b1;
                case (state)
                    MODE_OFF:    leds_q <= '0;
                    MODE_MIRROR: leds_q <= bus.switches;
                    MODE_ROTATE: begin
                        if (tick_hit) leds_q <= {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
                    end
                    MODE_BLINK: begin
                        phase  <= next_phase;
                        leds_q <= next_phase ? bus.switches : '0;
                    end
                    default:     leds_q <= '0;
                endcase
            end
        end
    end

    assign bus.leds = leds_q;
    assign bus.mode = state;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_mode_controller.sv
// Directed bench for led_mode_controller with N_LEDS=4 and TICK_DIV=4.
module tb_led_mode_controller;
    localparam int N  = 4;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [3:0] rot_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clk = ~clk;

    led_mode_controller_if #(.N_LEDS(N)) bus ();

    led_mode_controller #(
        .N_LEDS  (N),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [1:0] m, input logic [3:0] l, input logic t);
        check({tag, ".mode"}, 8'(bus.mode), 8'(m));
        check({tag, ".leds"}, 8'(bus.leds), 8'(l));
        check({tag, ".tick"}, 8'(bus.tick), 8'(t));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: button held through reset release must not count as a press
        rst = 1'b0;
        bus.button_center_db = 1'b1;
        bus.switches = 4'b0000;
        #1;
        check_all("reset", 2'd0, 4'b0000, 1'b0);
        repeat (2) cycle();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("held_mode", 8'(bus.mode), 8'd0);
            check("held_leds", 8'(bus.leds), 8'd0);
        end
        bus.button_center_db = 1'b0;
        repeat (3) cycle();

        // 2: four presses walk the mode ring, one advance per long hold
        for (int i = 0; i < 4; i++) begin
            bus.button_center_db = 1'b1;
            check("pre_press_mode", 8'(bus.mode), 8'(i));
            cycle();
            check("press_mode", 8'(bus.mode), 8'((i + 1) % 4));
            repeat (2) cycle();
            check("hold_mode", 8'(bus.mode), 8'((i + 1) % 4));
            bus.button_center_db = 1'b0;
            repeat (3) cycle();
        end

        // 3: MIRROR follows switches with one cycle of latency
        bus.button_center_db = 1'b1;
        cycle();
        check_all("mirror_entry", 2'd1, 4'b0000, 1'b0);
        bus.switches = 4'b1010;
        check("mirror_latency", 8'(bus.leds), 8'h0);
        cycle();
        check("mirror_1010", 8'(bus.leds), 8'hA);
        bus.switches = 4'b0101;
        cycle();
        check("mirror_0101", 8'(bus.leds), 8'h5);
        bus.button_center_db = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("mirror_stable", 8'(bus.leds), 8'h5);
        end

        // 4: ROTATE starts at bit 0 and steps every TD cycles, wrapping
        bus.button_center_db = 1'b1;
        cycle();
        check_all("rotate_entry", 2'd2, 4'b0001, 1'b0);
        bus.button_center_db = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (3) begin
                cycle();
                check("rotate_hold", 8'(bus.leds), 8'(k == 0 ? 4'b0001 : rot_seq[k-1]));
                check("rotate_notick", 8'(bus.tick), 8'd0);
            end
            cycle();
            check("rotate_step", 8'(bus.leds), 8'(rot_seq[k]));
            check("rotate_tick", 8'(bus.tick), 8'd1);
        end

        // 5: BLINK toggles every TD cycles; a press on a tick cycle wins
        bus.switches = 4'b0110;
        bus.button_center_db = 1'b1;
        cycle();
        check_all("blink_entry", 2'd3, 4'b0110, 1'b0);
        bus.button_center_db = 1'b0;
        repeat (3) begin
            cycle();
            check_all("blink_on", 2'd3, 4'b0110, 1'b0);
        end
        cycle();
        check_all("blink_off_edge", 2'd3, 4'b0000, 1'b1);
        repeat (3) begin
            cycle();
            check_all("blink_off", 2'd3, 4'b0000, 1'b0);
        end
        cycle();
        check_all("blink_on_edge", 2'd3, 4'b0110, 1'b1);
        bus.switches = 4'b1001;
        cycle();
        check_all("blink_sw_change", 2'd3, 4'b1001, 1'b0);
        repeat (2) cycle();
        check_all("blink_pre_tick", 2'd3, 4'b1001, 1'b0);
        bus.button_center_db = 1'b1;
        cycle();
        check_all("press_on_tick", 2'd0, 4'b0000, 1'b0);
        cycle();
        check_all("after_press_tick", 2'd0, 4'b0000, 1'b0);
        bus.button_center_db = 1'b0;

        // 6: asynchronous reset in the middle of ROTATE
        cycle();
        bus.button_center_db = 1'b1;
        cycle();
        check("re_mirror", 8'(bus.mode), 8'd1);
        bus.button_center_db = 1'b0;
        cycle();
        bus.button_center_db = 1'b1;
        cycle();
        check_all("re_rotate", 2'd2, 4'b0001, 1'b0);
        bus.button_center_db = 1'b0;
        repeat (8) cycle();
        check_all("pre_reset", 2'd2, 4'b0100, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_reset", 2'd0, 4'b0000, 1'b0);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check_all("post_reset", 2'd0, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
